// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
// rc4_pkg : sizing constants and KSA state encoding shared by the RC4 stages
// Revision : 1.0
// ============================================================================
package rc4_pkg;

  localparam int KEY_BYTES = 3;
  localparam int S_DEPTH   = 256;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;

  typedef enum logic [3:0] {
    KSA_IDLE = 4'd0,
    KSA_RD_I = 4'd1,
    KSA_WT_I = 4'd2,
    KSA_RD_J = 4'd3,
    KSA_WT_J = 4'd4,
    KSA_WR_I = 4'd5,
    KSA_WR_J = 4'd6,
    KSA_INC  = 4'd7,
    KSA_DONE = 4'd8
  } ksa_state_t;

endpackage
`default_nettype wire

// File: rtl/rc4_key_sel.sv
`default_nettype none
// ============================================================================
// rc4_key_sel : picks key byte k from the packed key, byte 0 in the top bits
// Revision : 1.0
// ============================================================================
module rc4_key_sel #(
  parameter int KEY_BYTES = 3,
  parameter int K_W       = 2
) (
  input  logic [rc4_pkg::DATA_W*KEY_BYTES-1:0] i_key,
  input  logic [K_W-1:0]                       i_k,
  output logic [rc4_pkg::DATA_W-1:0]           o_byte
);

  import rc4_pkg::*;

  always_comb begin
    o_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (i_k == K_W'(b)) begin
        o_byte = i_key[DATA_W*(KEY_BYTES-1-b) +: DATA_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rc4_ksa_swap.sv
`default_nettype none
// ============================================================================
// rc4_ksa_swap : RC4 key-scheduling pass over the shared S memory, 7 cycles/i
// Revision : 1.0
// ============================================================================
module rc4_ksa_swap #(
  parameter int KEY_BYTES = rc4_pkg::KEY_BYTES,
  parameter int MEM_DEPTH = rc4_pkg::S_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  sig_start,
  input  logic [rc4_pkg::DATA_W*KEY_BYTES-1:0]  secret_key,
  output logic [rc4_pkg::ADDR_W-1:0]            mem_address,
  output logic [rc4_pkg::DATA_W-1:0]            mem_data,
  input  logic [rc4_pkg::DATA_W-1:0]            mem_q,
  output logic                                  wren,
  output logic                                  t_done
);

  import rc4_pkg::*;

  localparam int                c_K_W      = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [ADDR_W-1:0] c_LAST_I   = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [c_K_W-1:0]  c_LAST_K   = c_K_W'(KEY_BYTES - 1);

  ksa_state_t          r_state;
  ksa_state_t          w_state_nxt;
  logic [ADDR_W-1:0]   r_i;
  logic [ADDR_W-1:0]   r_j;
  logic [c_K_W-1:0]    r_k;
  logic [DATA_W-1:0]   r_si;
  logic [DATA_W-1:0]   r_sj;
  logic [DATA_W-1:0]   w_key_byte;

  rc4_key_sel #(
    .KEY_BYTES (KEY_BYTES),
    .K_W       (c_K_W)
  ) u_key_sel (
    .i_key  (secret_key),
    .i_k    (r_k),
    .o_byte (w_key_byte)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= KSA_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // mem_q in WT_I/WT_J is the read of the address driven in the preceding RD_* cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_i  <= '0;
      r_j  <= '0;
      r_k  <= '0;
      r_si <= '0;
      r_sj <= '0;
    end else begin
      case (r_state)
        KSA_IDLE, KSA_DONE: begin
          if (sig_start) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
          end
        end
        KSA_WT_I: begin
          r_si <= mem_q;
          r_j  <= r_j + mem_q + w_key_byte;
        end
        KSA_WT_J: begin
          r_sj <= mem_q;
        end
        KSA_INC: begin
          if (r_i != c_LAST_I) begin
            r_i <= r_i + 1'b1;
            r_k <= (r_k == c_LAST_K) ? '0 : r_k + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_address = '0;
    mem_data    = '0;
    wren        = 1'b0;
    t_done      = 1'b0;
    case (r_state)
      KSA_IDLE: begin
        if (sig_start) w_state_nxt = KSA_RD_I;
      end
      KSA_RD_I: begin
        mem_address = r_i;
        w_state_nxt = KSA_WT_I;
      end
      KSA_WT_I: w_state_nxt = KSA_RD_J;
      KSA_RD_J: begin
        mem_address = r_j;
        w_state_nxt = KSA_WT_J;
      end
      KSA_WT_J: w_state_nxt = KSA_WR_I;
      KSA_WR_I: begin
        mem_address = r_i;
        mem_data    = r_sj;
        wren        = 1'b1;
        w_state_nxt = KSA_WR_J;
      end
      KSA_WR_J: begin
        mem_address = r_j;
        mem_data    = r_si;
        wren        = 1'b1;
        w_state_nxt = KSA_INC;
      end
      KSA_INC: begin
        w_state_nxt = (r_i == c_LAST_I) ? KSA_DONE : KSA_RD_I;
      end
      KSA_DONE: begin
        t_done = 1'b1;
        if (sig_start) w_state_nxt = KSA_RD_I;
      end
      default: w_state_nxt = KSA_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rc4_ksa_swap.sv
`default_nettype none
// ============================================================================
// tb_rc4_ksa_swap : scoreboard bench for rc4_ksa_swap with a 1-cycle S memory
// Revision : 1.0
// ============================================================================
module tb_rc4_ksa_swap;

  typedef logic [7:0] arr_t [256];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sig_start;
  logic [23:0] secret_key;
  logic [7:0]  mem_address;
  logic [7:0]  mem_data;
  logic [7:0]  mem_q;
  logic        wren;
  logic        t_done;

  logic [7:0]  mem [256];
  logic        load_id;
  logic [15:0] exp_q [$];
  logic [15:0] mon_e;
  int          wr_idx = 0;
  int          total  = 0;
  int          bad    = 0;

  always #5 clk = ~clk;

  rc4_ksa_swap dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sig_start   (sig_start),
    .secret_key  (secret_key),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_q       (mem_q),
    .wren        (wren),
    .t_done      (t_done)
  );

  // registered-address S memory; load_id restores s[a]=a
  always @(posedge clk) begin
    if (load_id) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
    end else if (wren) begin
      mem[mem_address] <= mem_data;
    end
    mem_q <= mem[mem_address];
  end

  // write monitor: every write must match the head of the expected queue
  always begin
    @(posedge clk);
    #1;
    if (wren === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d, no write expected",
                 mem_address, mem_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mem_address, mem_data} !== mon_e) begin
          bad++;
          $display("FAIL write_%0d: got addr=%0d data=%0d expected addr=%0d data=%0d",
                   wr_idx, mem_address, mem_data, mon_e[15:8], mon_e[7:0]);
        end
      end
      wr_idx++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // software KSA: pushes the expected write pair per iteration and updates s
  function automatic void model_run(input logic [23:0] key, inout arr_t s);
    logic [7:0] j;
    logic [7:0] t;
    logic [7:0] kb;
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kb = key[8*(2 - (i % 3)) +: 8];
      j  = j + s[i] + kb;
      exp_q.push_back({8'(i), s[j]});
      exp_q.push_back({j, s[i]});
      t    = s[i];
      s[i] = s[j];
      s[j] = t;
    end
  endfunction

  function automatic void identity(output arr_t s);
    for (int a = 0; a < 256; a++) s[a] = 8'(a);
  endfunction

  task automatic outs_zero(input string tag);
    chk({tag, "_addr"},   32'(mem_address), 0);
    chk({tag, "_data"},   32'(mem_data),    0);
    chk({tag, "_wren"},   32'(wren),        0);
    chk({tag, "_t_done"}, 32'(t_done),      0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    load_id = 1'b1;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    load_id = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    sig_start = 1'b1;
    @(negedge clk);
    sig_start = 1'b0;
  endtask

  // n counts cycles after E0; returns the cycle of first wren and of t_done
  task automatic run_timed(input bit hold, output int n_done, output int n_wr);
    n_wr = 0;
    @(negedge clk);
    sig_start = 1'b1;
    @(negedge clk);
    if (!hold) sig_start = 1'b0;
    n_done = 1;
    while (t_done !== 1'b1 && n_done < 4000) begin
      if (wren === 1'b1 && n_wr == 0) n_wr = n_done;
      @(negedge clk);
      n_done++;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 0);
  endtask

  task automatic mem_check(input string tag, input arr_t s);
    int nbad;
    nbad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== s[a]) nbad++;
    chk({tag, "_array_mismatches"}, 32'(nbad), 0);
    chk({tag, "_writes_left"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    arr_t s;
    int   nd;
    int   nw;
    rst_n      = 1'b0;
    sig_start  = 1'b0;
    secret_key = 24'h000000;
    load_id    = 1'b1;
    repeat (3) @(negedge clk);
    outs_zero("reset");
    rst_n   = 1'b1;
    load_id = 1'b0;

    // key 000000: j=0, j=1, then j=3 with a real swap
    secret_key = 24'h000000;
    exp_q.push_back({8'd0, 8'd0}); exp_q.push_back({8'd0, 8'd0});
    exp_q.push_back({8'd1, 8'd1}); exp_q.push_back({8'd1, 8'd1});
    exp_q.push_back({8'd2, 8'd3}); exp_q.push_back({8'd3, 8'd2});
    pulse_start();
    drain("key0");
    do_reset();
    exp_q.delete();

    // key 010203: j=1 then j=3
    secret_key = 24'h010203;
    exp_q.push_back({8'd0, 8'd1}); exp_q.push_back({8'd1, 8'd0});
    exp_q.push_back({8'd1, 8'd3}); exp_q.push_back({8'd3, 8'd0});
    pulse_start();
    drain("key010203");
    do_reset();
    exp_q.delete();

    // key 000249: full run against software KSA, timing and DONE hold
    secret_key = 24'h000249;
    identity(s);
    model_run(secret_key, s);
    run_timed(1'b0, nd, nw);
    chk("first_wren_cycle", 32'(nw), 5);
    chk("done_cycle", 32'(nd), 1793);
    nw = 0;
    repeat (10) begin
      @(negedge clk);
      if (t_done !== 1'b1) nw++;
    end
    chk("done_held_low_cycles", 32'(nw), 0);
    mem_check("full", s);

    // reset in WR_I of iteration 100, then a clean rerun
    do_reset();
    identity(s);
    model_run(secret_key, s);
    pulse_start();
    nd = 1;
    while (nd < 705) begin
      @(negedge clk);
      nd++;
    end
    chk("iter100_wr_i_wren", 32'(wren), 1);
    chk("iter100_wr_i_addr", 32'(mem_address), 100);
    rst_n = 1'b0;
    @(negedge clk);
    outs_zero("mid_reset");
    rst_n = 1'b1;
    exp_q.delete();
    nw = 0;
    repeat (5) begin
      @(negedge clk);
      if (wren !== 1'b0 || t_done !== 1'b0) nw++;
    end
    chk("idle_after_reset", 32'(nw), 0);
    do_reset();
    identity(s);
    model_run(secret_key, s);
    run_timed(1'b0, nd, nw);
    chk("rerun_done_cycle", 32'(nd), 1793);
    mem_check("rerun", s);

    // sig_start held high: no restart while busy, one-cycle DONE, auto restart
    secret_key = 24'h010203;
    do_reset();
    identity(s);
    model_run(secret_key, s);
    model_run(secret_key, s);
    run_timed(1'b1, nd, nw);
    chk("held_done_cycle", 32'(nd), 1793);
    @(negedge clk);
    chk("held_done_one_cycle", 32'(t_done), 0);
    sig_start = 1'b0;
    nd = 1;
    while (t_done !== 1'b1 && nd < 4000) begin
      @(negedge clk);
      nd++;
    end
    chk("auto_restart_done_cycle", 32'(nd), 1793);
    mem_check("held", s);

    // one-cycle pulse in DONE gives a complete further run
    model_run(secret_key, s);
    run_timed(1'b0, nd, nw);
    chk("pulse_from_done_cycle", 32'(nd), 1793);
    mem_check("pulse_rerun", s);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rc4_ksa_swap.md
# rc4_ksa_swap

Key-scheduling stage of the RC4 decryption datapath. It runs after the S-array init stage has written s[i]=i into the shared 256×8 working memory. On `sig_start` it performs the 256-iteration KSA: j = j + s[i] + key[i mod 3], then swaps s[i] and s[j]. It drives the same single-port memory through the address, write-data and write-enable bus, and signals completion on `t_done`. The stream-generation stage is the consumer.

## Interface
- `KEY_BYTES`, 3: secret key length in bytes, fixed by the lab key width.
- `MEM_DEPTH`, 256: S-array entries; i and j are 8 bits wide.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `sig_start`  in  1: start request, sampled only in IDLE or DONE.
- `secret_key`  in  24: key, stable while busy. Byte 0 is `[23:16]`, byte 1 is `[15:8]`, byte 2 is `[7:0]`.
- `mem_address`  out  8: S-memory address.
- `mem_data`  out  8: S-memory write data.
- `mem_q`  in  8: S-memory read data, valid the cycle after the address was presented (registered-address RAM).
- `wren`  out  1: S-memory write enable.
- `t_done`  out  1: KSA complete; high in DONE only.

## Operation
- Registers:
  - i[7:0]
  - j[7:0]
  - k, a mod-3 key index in 0..2
  - si[7:0], captured s[i]
  - sj[7:0], captured s[j]
  - state
- States and transitions:
  - IDLE: sig_start=1 → RD_I, with i=0, j=0, k=0.
  - RD_I: mem_address=i → WT_I.
  - WT_I: capture si=mem_q. Update j ← j + mem_q + key_byte[k], mod 256 (8-bit wrap, carries dropped). → RD_J.
  - RD_J: mem_address=j, using the new j → WT_J.
  - WT_J: capture sj=mem_q → WR_I.
  - WR_I: mem_address=i, mem_data=sj, wren=1 → WR_J.
  - WR_J: mem_address=j, mem_data=si, wren=1 → INC.
  - INC: if i==255 → DONE. Otherwise i ← i+1, k ← (k==2)?0:k+1, → RD_I.
  - DONE: t_done=1. sig_start=1 → RD_I with i=j=k=0, a full re-run. Otherwise stay.
- Outputs are Moore decodes of state plus registers. Outside WR_I/WR_J, wren=0 and mem_data=0. In IDLE/DONE, mem_address=0.
- Boundary conditions:
  - i==j: both writes carry the same value, so memory is unchanged. No special case is needed.
  - sig_start while busy (RD_I..INC): ignored.
  - secret_key changes while busy: undefined result (caller's responsibility).
  - rst_n=0 at any edge, including mid-iteration: next state IDLE, all registers and outputs 0. Memory keeps its partial contents; no rollback.
- Reset values: mem_address=0, mem_data=0, wren=0, t_done=0, i=j=k=0, si=sj=0.

## Timing
- 7 cycles per iteration (RD_I, WT_I, RD_J, WT_J, WR_I, WR_J, INC).
- Let E0 be the edge that samples sig_start=1 in IDLE.
  - RD_I is the cycle after E0.
  - First wren=1 is in the 5th cycle after E0.
  - t_done first goes high 1793 cycles after E0 (1 + 256×7).
- Read latency is exactly 1 cycle. The mem_q value consumed in WT_* belongs to the address driven in the preceding RD_* cycle.
- No back-pressure; the block owns the memory port while busy.
- Memory-port muxing between stages is handled outside this block.
- Total run at 50 MHz: ≈35.9 µs.

## Structure
- Shared package `rc4_pkg`:
  - state enum `ksa_state_t`
  - `KEY_BYTES`=3
  - `S_DEPTH`=256
  - `ADDR_W`=8
  - `DATA_W`=8

  The init and PRGA stages reuse the sizing constants.
- One sub-module, `rc4_key_sel`: combinational 3:1 byte select from `secret_key` by k. Instantiated once.
- The mod-3 counter stays in the top FSM.

## Test plan
- Bench memory model: 256×8, 1-cycle read latency, preloaded s[i]=i. The bench checks every write transaction.
- Key 24'h000000:
  - i=0 and i=1 write their own values back (j=0, then j=1).
  - i=2 gives j=3; writes are addr 2←3, then addr 3←2.
- Key 24'h010203:
  - i=0 gives j=1; writes 0←1, 1←0.
  - i=1 gives j=3; writes 1←3, 3←0.
- Key 24'h000249: final 256-byte array matches a software KSA golden model. t_done rises exactly 1793 cycles after E0 and stays high.
- rst_n low at iteration 100, in WR_I:
  - next cycle all outputs are 0 and state is IDLE;
  - a fresh sig_start restarts from i=j=0;
  - timing again gives 1793 cycles (memory reloaded to identity first).
- sig_start held high throughout a run:
  - no restart while busy;
  - on reaching DONE, the block restarts next cycle (t_done high for exactly 1 cycle);
  - a 1-cycle sig_start pulse in DONE yields a complete second run.
